ser_tx_scheduler: RTL and testbench
===================================

SER_TX_SCHEDULER -- requirements
Module: ser_tx_scheduler

Interface
REQ-001 Parameter WORD_CYCLES, default 4, SHALL set the div_8_clk cycles one 32-bit word occupies on the 32-to-8 converter.
REQ-002 Parameter SYNC_PERIOD, default 64, SHALL set the idle cycles after which a sync word is inserted.
REQ-003 Parameter SYNC_WORD, default 32'hBCBC_BCBC, SHALL set the link sync/idle pattern.
REQ-004 div_8_clk  in  1  SHALL be the single clock, shared with the 32-to-8 converter.
REQ-005 rst  in  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of div_8_clk.
REQ-006 req_valid  in  2  SHALL carry the per-requester word-valid flags.
REQ-007 req_data0, req_data1  in  32 each  SHALL carry the requester words.
REQ-008 req_ready  out  2  SHALL be the per-requester accept strobes; a transfer occurs when valid and ready are both high.
REQ-009 tx_out  out  1  SHALL be the one-cycle load strobe to the converter.
REQ-010 data_in  out  32  SHALL be the word presented to the converter, held stable for WORD_CYCLES cycles from the tx_out cycle.
REQ-011 busy  out  1  SHALL be high while a word is being shifted.
REQ-012 grant_id  out  1  SHALL identify the source of the word in flight.
REQ-013 sync_active  out  1  SHALL be high while the word in flight is SYNC_WORD.
REQ-014 word_cnt  out  16  SHALL count requester words sent, excluding sync words, and wrap modulo 2^16.

Function
REQ-015 FSM states SHALL be IDLE, LOAD and SHIFT.
REQ-016 In IDLE, req_ready SHALL be one-hot to the arbitration winner when any req_valid is high, and zero otherwise.
REQ-017 Arbitration SHALL be round-robin, with a pointer that toggles after each accepted requester word; after reset, requester 0 has priority.
REQ-018 A transfer in IDLE SHALL move the FSM to LOAD on the next cycle, with data_in set to the captured word and grant_id set to the winner.
REQ-019 In LOAD, tx_out SHALL be 1 for exactly one cycle, busy SHALL be 1, and the beat counter SHALL be 0.
REQ-020 The FSM SHALL leave LOAD for SHIFT, and SHIFT SHALL increment the beat counter each cycle until it reaches WORD_CYCLES-1.
REQ-021 In the SHIFT cycle where beat = WORD_CYCLES-1, req_ready SHALL be asserted as in IDLE, so back-to-back words appear on tx_out every WORD_CYCLES cycles.
REQ-022 At the end of a word, the FSM SHALL go to LOAD if a transfer occurred in the final beat, and to IDLE otherwise.
REQ-023 Latency from the accepting transfer to tx_out SHALL be exactly 1 cycle.
REQ-024 An idle counter SHALL increment each IDLE cycle with no transfer, and clear on a transfer or on sync insertion.
REQ-025 When the idle counter reaches SYNC_PERIOD-1 with no req_valid, the FSM SHALL load SYNC_WORD via LOAD with sync_active=1, without asserting req_ready.
REQ-026 If req_valid and the sync threshold coincide, the requester word SHALL win and no sync word SHALL be sent.
REQ-027 A req_valid that arrives during a sync word SHALL be accepted in its final beat.
REQ-028 word_cnt SHALL increment in the LOAD cycle of each requester word and wrap from 16'hFFFF to 0.
REQ-029 data_in and grant_id SHALL be unchanged by req_data changes while busy.

Reset
REQ-030 While rst is high, on each edge: state IDLE; tx_out 0; data_in 0; busy 0; grant_id 0; sync_active 0; word_cnt 0; idle counter 0; beat counter 0; rr pointer 0; req_ready 0.
REQ-031 Reset asserted mid-word SHALL abort the word, and nothing already accepted SHALL be replayed.
REQ-032 After rst deasserts, the first transfer SHALL be possible in the first cycle.

Structure
REQ-033 A shared package ser_link_pkg SHALL hold the FSM state enum, SYNC_WORD default and WORD_CYCLES default.
REQ-034 The round-robin arbiter SHALL be one sub-module, rr_arb2, with inputs req[1:0] and advance, and output grant one-hot[1:0].
REQ-035 The block SHALL sit between the requesters and the existing tx_out/data_in inputs of the 32-to-8/serializer datapath, replacing direct drive.

Verification
REQ-036 Single word: req_valid=01, req_data0=32'h1234_5678 -> ready0 the same cycle; tx_out next cycle with data_in=32'h1234_5678 held 4 cycles; word_cnt=1.
REQ-037 Contention: both valid continuously with data 32'hA0.., 32'hB0.. -> grants alternate 0,1,0,1; tx_out every 4 cycles; no gap.
REQ-038 Idle: no valid for 64 cycles -> tx_out with data_in=32'hBCBC_BCBC and sync_active=1; word_cnt unchanged; valid then raised mid-sync -> accepted in beat 3.
REQ-039 Coincidence: valid raised in idle cycle 63 -> requester word sent; no sync word.
REQ-040 Reset mid-SHIFT (beat 2) -> next cycle all outputs at reset values; no tx_out until a new transfer.
REQ-041 Wrap: preload traffic to 65536 words -> word_cnt returns to 0.

Source files
------------

// File: rtl/ser_link_pkg.sv
// Shared link definitions: scheduler FSM states and link-level defaults.
package ser_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } link_state_t;

    localparam int          WORD_CYCLES_DEFAULT = 4;
    localparam int          SYNC_PERIOD_DEFAULT = 64;
    localparam logic [31:0] SYNC_WORD_DEFAULT   = 32'hBCBC_BCBC;

endpackage

// File: rtl/ser_tx_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer flips on every accepted word.
module rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic       ptr_reg;
    logic [1:0] prio_hit;

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= 1'b0;
        end else if (advance) begin
            ptr_reg <= ~ptr_reg;
        end
    end

    // A requester wins outright when it holds priority, otherwise only if the other is silent.
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        assign prio_hit[gi] = req[gi] && (ptr_reg == 1'(gi));
        assign grant[gi]    = prio_hit[gi] || (req[gi] && !(|prio_hit));
    end

endmodule

// File: rtl/ser_tx_scheduler.sv
// Schedules requester words and idle sync words onto the 32-to-8 converter,
// loading one word every WORD_CYCLES cycles with zero-bubble back-to-back traffic.
module ser_tx_scheduler
    import ser_link_pkg::*;
#(
    parameter int          WORD_CYCLES = WORD_CYCLES_DEFAULT,
    parameter int          SYNC_PERIOD = SYNC_PERIOD_DEFAULT,
    parameter logic [31:0] SYNC_WORD   = SYNC_WORD_DEFAULT
) (
    input  logic        div_8_clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    output logic [1:0]  req_ready,
    output logic        tx_out,
    output logic [31:0] data_in,
    output logic        busy,
    output logic        grant_id,
    output logic        sync_active,
    output logic [15:0] word_cnt
);

    localparam int BEAT_W = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
    localparam int IDLE_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(WORD_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(SYNC_PERIOD - 1);

    link_state_t        state_reg, state_next;
    logic [BEAT_W-1:0]  beat_reg;
    logic [IDLE_W-1:0]  idle_cnt_reg;
    logic [31:0]        data_reg;
    logic               grant_reg;
    logic               sync_reg;
    logic [15:0]        word_cnt_reg;

    logic [1:0]         arb_grant;
    logic               last_beat;
    logic               arb_window;
    logic               xfer;
    logic               sync_fire;

    assign last_beat  = (state_reg == SHIFT) && (beat_reg == LAST_BEAT);
    // Acceptance is allowed while idle and in the final beat, never during reset.
    assign arb_window = !rst && ((state_reg == IDLE) || last_beat);
    assign xfer       = |req_ready;
    assign sync_fire  = !rst && (state_reg == IDLE) && (idle_cnt_reg == IDLE_LIMIT)
                        && !(|req_valid);

    rr_arb2 u_arb (
        .clk     (div_8_clk),
        .srst    (rst),
        .req     (req_valid),
        .advance (xfer),
        .grant   (arb_grant)
    );

    always_ff @(posedge div_8_clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = (xfer || sync_fire) ? LOAD : IDLE;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (last_beat) state_next = xfer ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = arb_window ? arb_grant : 2'b00;
        tx_out      = (state_reg == LOAD);
        busy        = (state_reg != IDLE);
        sync_active = sync_reg && (state_reg != IDLE);
    end

    always_ff @(posedge div_8_clk) begin
        if (rst) begin
            beat_reg     <= '0;
            idle_cnt_reg <= '0;
            data_reg     <= '0;
            grant_reg    <= 1'b0;
            sync_reg     <= 1'b0;
            word_cnt_reg <= '0;
        end else begin
            // Word register only moves on a new load, so requester data is ignored while busy.
            if (xfer) begin
                data_reg  <= arb_grant[1] ? req_data1 : req_data0;
                grant_reg <= arb_grant[1];
                sync_reg  <= 1'b0;
            end else if (sync_fire) begin
                data_reg  <= SYNC_WORD;
                grant_reg <= 1'b0;
                sync_reg  <= 1'b1;
            end

            case (state_reg)
                LOAD:    beat_reg <= BEAT_W'(1);
                SHIFT:   beat_reg <= last_beat ? '0 : beat_reg + BEAT_W'(1);
                default: beat_reg <= '0;
            endcase

            if (xfer || sync_fire) begin
                idle_cnt_reg <= '0;
            end else if (state_reg == IDLE) begin
                idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
            end

            if ((state_reg == LOAD) && !sync_reg) begin
                word_cnt_reg <= word_cnt_reg + 16'd1;
            end
        end
    end

    assign data_in  = data_reg;
    assign grant_id = grant_reg;
    assign word_cnt = word_cnt_reg;

endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Randomized and directed bench for ser_tx_scheduler against a word-timeline model.
module tb_ser_tx_scheduler;

    localparam int          WC   = 4;
    localparam int          SP   = 64;
    localparam logic [31:0] SYNC = 32'hBCBC_BCBC;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_data0;
    logic [31:0] req_data1;
    logic [1:0]  req_ready;
    logic        tx_out;
    logic [31:0] data_in;
    logic        busy;
    logic        grant_id;
    logic        sync_active;
    logic [15:0] word_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    ser_tx_scheduler #(.WORD_CYCLES(WC), .SYNC_PERIOD(SP), .SYNC_WORD(SYNC)) dut (
        .div_8_clk   (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_ready   (req_ready),
        .tx_out      (tx_out),
        .data_in     (data_in),
        .busy        (busy),
        .grant_id    (grant_id),
        .sync_active (sync_active),
        .word_cnt    (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a word occupies WC consecutive cycles; m_left counts the cycles still owed.
    logic        m_known = 1'b0;
    logic        m_busy, m_sync, m_src, m_prio;
    int          m_left, m_idle;
    logic [31:0] m_word;
    logic [15:0] m_sent;
    logic [15:0] pre_val;
    bit          pre_tog  = 1'b0;
    bit          pre_seen = 1'b0;

    always @(negedge clk) begin
        logic [1:0] e_ready;
        logic       pick;
        logic       was_busy;
        if (pre_tog != pre_seen) begin
            m_sent   = pre_val;
            pre_seen = pre_tog;
        end
        e_ready = 2'b00;
        if (m_known && !rst && (!m_busy || m_left == 1) && req_valid != 2'b00) begin
            pick    = req_valid[m_prio] ? m_prio : !m_prio;
            e_ready = pick ? 2'b10 : 2'b01;
        end
        if (m_known) begin
            check("req_ready",   req_ready,   e_ready);
            check("tx_out",      tx_out,      m_busy && m_left == WC);
            check("busy",        busy,        m_busy);
            check("data_in",     data_in,     m_word);
            check("grant_id",    grant_id,    m_src);
            check("sync_active", sync_active, m_busy && m_sync);
            check("word_cnt",    word_cnt,    m_sent);
            if (tx_out === 1'b1)
                $display("word: src=%0d data=%h sync=%0b cnt=%0d", grant_id, data_in, sync_active, word_cnt);
        end
        if (rst) begin
            m_known = 1'b1;
            m_busy = 1'b0; m_sync = 1'b0; m_src = 1'b0; m_prio = 1'b0;
            m_left = 0; m_idle = 0; m_word = '0; m_sent = '0;
        end else if (m_known) begin
            was_busy = m_busy;
            if (m_busy) begin
                if (m_left == WC && !m_sync) m_sent = m_sent + 16'd1;
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end
            if (e_ready != 2'b00) begin
                m_busy = 1'b1; m_left = WC; m_sync = 1'b0;
                m_src  = e_ready[1];
                m_word = e_ready[1] ? req_data1 : req_data0;
                m_prio = !m_prio;
                m_idle = 0;
            end else if (!was_busy && m_idle == SP - 1 && req_valid == 2'b00) begin
                m_busy = 1'b1; m_left = WC; m_sync = 1'b1;
                m_src  = 1'b0; m_word = SYNC;
                m_idle = 0;
            end else if (!was_busy) begin
                m_idle++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int  n;
        bit  found;
        int  mode;
        rst = 1'b1;
        req_valid = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        do_reset();

        // Reset values
        #3;
        check("rst_busy", busy, 0);
        check("rst_tx_out", tx_out, 0);
        check("rst_data_in", data_in, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_ready", req_ready, 0);

        // Single word
        req_valid = 2'b01; req_data0 = 32'h1234_5678;
        #3 check("single_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00; req_data0 = 32'hDEAD_DEAD;
        #3 check("single_tx", tx_out, 1);
        check("single_data", data_in, 32'h1234_5678);
        tick(); tick(); tick();
        #3 check("single_hold", data_in, 32'h1234_5678);
        check("single_tx_off", tx_out, 0);
        tick();
        #3 check("single_done", busy, 0);
        check("single_cnt", word_cnt, 1);

        // Contention: alternating grants, one load every WC cycles
        do_reset();
        req_valid = 2'b11; req_data0 = 32'hA0A0_A0A0; req_data1 = 32'hB0B0_B0B0;
        #3 check("cont_first_ready", req_ready, 2'b01);
        for (int i = 0; i < 4; i++) begin
            tick();
            #3 check("cont_tx", tx_out, 1);
            check("cont_grant", grant_id, i % 2);
            check("cont_data", data_in, (i % 2) ? 32'hB0B0_B0B0 : 32'hA0A0_A0A0);
            repeat (WC - 1) tick();
        end
        req_valid = 2'b00;

        // Idle: sync after SP idle cycles, then a request joins in the last sync beat
        do_reset();
        n = 0; found = 0;
        while (n < 200) begin
            #3;
            if (tx_out) begin found = 1; break; end
            tick();
            n++;
        end
        check("sync_found", found, 1);
        check("sync_latency", n, 64);
        check("sync_data", data_in, 32'hBCBC_BCBC);
        check("sync_flag", sync_active, 1);
        check("sync_cnt", word_cnt, 0);
        tick();
        req_valid = 2'b10; req_data1 = 32'hCAFE_F00D;
        #3 check("sync_b1_ready", req_ready, 2'b00);
        tick();
        #3 check("sync_b2_ready", req_ready, 2'b00);
        tick();
        #3 check("sync_b3_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        #3 check("after_sync_tx", tx_out, 1);
        check("after_sync_data", data_in, 32'hCAFE_F00D);
        check("after_sync_grant", grant_id, 1);
        check("after_sync_flag", sync_active, 0);

        // Coincidence at the sync threshold
        do_reset();
        repeat (SP - 1) tick();
        req_valid = 2'b01; req_data0 = 32'h0D15_EA5E;
        #3 check("coin_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        #3 check("coin_tx", tx_out, 1);
        check("coin_data", data_in, 32'h0D15_EA5E);
        check("coin_sync", sync_active, 0);

        // Reset in SHIFT beat 2
        do_reset();
        req_valid = 2'b01; req_data0 = 32'h55AA_55AA;
        tick(); req_valid = 2'b00;
        tick(); tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        #3 check("mid_rst_busy", busy, 0);
        check("mid_rst_data", data_in, 0);
        check("mid_rst_cnt", word_cnt, 0);
        found = 0;
        repeat (10) begin
            tick();
            #3 if (tx_out) found = 1;
        end
        check("mid_rst_no_replay", found, 0);

        // Counter wrap from a preloaded value
        do_reset();
        force dut.word_cnt_reg = 16'hFFFE;
        pre_val = 16'hFFFE;
        pre_tog = ~pre_tog;
        #1 release dut.word_cnt_reg;
        req_valid = 2'b01; req_data0 = 32'h1111_1111;
        tick(); tick();
        #3 check("wrap_ffff", word_cnt, 16'hFFFF);
        tick(); tick(); tick(); req_valid = 2'b00;
        tick();
        #3 check("wrap_zero", word_cnt, 16'h0000);

        // Randomized traffic, idle stretches and occasional resets
        for (int seg = 0; seg < 40; seg++) begin
            mode = $urandom_range(0, 3);
            for (int c = 0; c < 100; c++) begin
                rst = ($urandom_range(0, 399) == 0);
                case (mode)
                    0:       req_valid = 2'b00;
                    1:       req_valid = 2'($urandom_range(0, 3));
                    2:       req_valid = 2'b11;
                    default: req_valid = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                endcase
                req_data0 = $urandom;
                req_data1 = $urandom;
                tick();
            end
        end
        rst = 1'b0;
        req_valid = 2'b00;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
